// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Holds the FSM state encoding and the default burst limit.
package dm_arb_pkg;

    localparam int BURST_MAX_DEF = 4;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;

endpackage

// File: rtl/dm_arb_rsp.sv
// Read-response register for one arbiter port.
// Captures DM read data one cycle after a granted read.
module dm_arb_rsp (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire,
    input  logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic [31:0] rdata
);

    // Pulse rvalid after a granted read; rdata holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= 32'd0;
        end else begin
            rvalid <= fire;
            if (fire) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// Owner keeps the port for up to BURST_MAX grants while the other waits.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = $clog2(BURST_MAX + 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          last;

    logic          any;
    logic          sel;
    logic          grant;
    logic          burst_open;
    logic          same_owner;

    assign burst_open = (cnt < CW'(BURST_MAX));

    // Pick the port to serve this cycle from owner, burst count and requests
    always_comb begin
        any = 1'b0;
        sel = 1'b0;
        case (state)
            OWN0: begin
                if (req0 && (burst_open || !req1)) begin
                    any = 1'b1;
                    sel = 1'b0;
                end else if (req1) begin
                    any = 1'b1;
                    sel = 1'b1;
                end
            end
            OWN1: begin
                if (req1 && (burst_open || !req0)) begin
                    any = 1'b1;
                    sel = 1'b1;
                end else if (req0) begin
                    any = 1'b1;
                    sel = 1'b0;
                end
            end
            default: begin
                if (req0 && req1) begin
                    any = 1'b1;
                    sel = ~last;
                end else if (req0 || req1) begin
                    any = 1'b1;
                    sel = req1;
                end
            end
        endcase
    end

    assign grant      = any && !reset;
    assign gnt0       = req0 && !sel && !reset;
    assign gnt1       = req1 && sel && !reset;
    assign same_owner = (state == OWN0 && !sel) ||
                        (state == OWN1 && sel);

    assign mem_addr  = sel ? addr1 : addr0;
    assign mem_wdata = sel ? wdata1 : wdata0;
    assign mem_we    = grant && (sel ? we1 : we0);

    // Track owner, burst length and the last winner for tie-breaks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else if (grant) begin
            state <= sel ? OWN1 : OWN0;
            last  <= sel;
            if (!same_owner) begin
                cnt <= CW'(1);
            end else if (burst_open) begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            state <= IDLE;
            cnt   <= '0;
        end
    end

    dm_arb_rsp u_rsp0 (
        .clk       (clk),
        .reset     (reset),
        .fire      (gnt0 && !we0),
        .mem_rdata (mem_rdata),
        .rvalid    (rvalid0),
        .rdata     (rdata0)
    );

    dm_arb_rsp u_rsp1 (
        .clk       (clk),
        .reset     (reset),
        .fire      (gnt1 && !we1),
        .mem_rdata (mem_rdata),
        .rvalid    (rvalid1),
        .rdata     (rdata1)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios then random traffic.
// A behavioural arbitration/memory model supplies every expected value.
module tb_dm_arbiter;

    localparam int BM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dm [16];

    int checks   = 0;
    int failures = 0;

    int          m_owner;
    int          m_run;
    int          m_last;
    bit          m_rv [2];
    logic [31:0] m_rd [2];
    logic [31:0] ref_mem [16];

    dm_arbiter #(.BURST_MAX(BM), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = dm[(mem_addr >> 2) & 32'd15];

    always @(posedge clk) begin
        if (mem_we) dm[(mem_addr >> 2) & 32'd15] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        m_rv    = '{0, 0};
        m_rd    = '{32'd0, 32'd0};
    endtask

    function automatic int pick(input logic r0, input logic r1);
        logic ro, rt;
        if (!r0 && !r1) return -1;
        if (m_owner < 0) begin
            if (r0 && r1) return 1 - m_last;
            return r0 ? 0 : 1;
        end
        ro = (m_owner == 1) ? r1 : r0;
        rt = (m_owner == 1) ? r0 : r1;
        if (ro && (m_run < BM || !rt)) return m_owner;
        return 1 - m_owner;
    endfunction

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // One clock: check grant/mem outputs, advance model, check responses
    task automatic cycle(input string tag, output int g,
                         output logic [1:0] og);
        logic        rs, w0, w1, w;
        logic [31:0] a0, a1, d0, d1, a, d;
        int          idx;
        #1;
        rs = reset;
        w0 = we0; w1 = we1; a0 = addr0; a1 = addr1; d0 = wdata0; d1 = wdata1;
        g  = rs ? -1 : pick(req0, req1);
        og = {gnt1, gnt0};
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(g == 0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(g == 1));
        w = (g == 1) ? w1 : w0;
        a = (g == 1) ? a1 : a0;
        d = (g == 1) ? d1 : d0;
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(g >= 0 && w));
        chk({tag, ".mem_addr"}, mem_addr, a);
        chk({tag, ".mem_wdata"}, mem_wdata, d);
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
        end else begin
            m_rv = '{0, 0};
            if (g >= 0) begin
                idx = int'((a >> 2) & 32'd15);
                if (w) ref_mem[idx] = d;
                else begin
                    m_rv[g] = 1;
                    m_rd[g] = ref_mem[idx];
                end
                if (g == m_owner) m_run = (m_run < BM) ? m_run + 1 : m_run;
                else m_run = 1;
                m_owner = g;
                m_last  = g;
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
        end
        chk({tag, ".rvalid0"}, 32'(rvalid0), 32'(m_rv[0]));
        chk({tag, ".rdata0"}, rdata0, m_rd[0]);
        chk({tag, ".rvalid1"}, 32'(rvalid1), 32'(m_rv[1]));
        chk({tag, ".rdata1"}, rdata1, m_rd[1]);
    endtask

    task automatic pulse_reset();
        int         g;
        logic [1:0] og;
        reset = 1'b1;
        cycle("rst", g, og);
        reset = 1'b0;
    endtask

    initial begin
        int          g;
        logic [1:0]  og;
        int          exp24 [10];
        bit          pr [2];
        logic        pw [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];

        for (int i = 0; i < 16; i++) begin
            dm[i]      = (32'(i) * 32'h0101_0101) ^ 32'h5A;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A;
        end
        dm[4]      = 32'h1234;
        ref_mem[4] = 32'h1234;
        model_reset();
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;

        // reset holds grants and mem_we low even with a request
        drive(0, 1'b1, 1'b1, 32'h8, 32'h77);
        #1;
        chk("rst.gnt0", 32'(gnt0), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.rvalid0", 32'(rvalid0), 32'd0);
        chk("rst.rdata0", rdata0, 32'd0);
        cycle("rst_hold", g, og);
        reset = 1'b0;

        // single read on port 0
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        cycle("r022", g, og);
        chk("r022.og", 32'(og), 32'b01);
        chk("r022.rvalid0", 32'(rvalid0), 32'd1);
        chk("r022.rdata0", rdata0, 32'h1234);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r022.idle", g, og);

        // tie-break from IDLE alternates starting with port 0
        pulse_reset();
        drive(0, 1'b1, 1'b0, 32'h4, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h8, 32'd0);
        cycle("r023.a", g, og);
        chk("r023.first", 32'(og), 32'b01);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r023.idle", g, og);
        drive(0, 1'b1, 1'b0, 32'hC, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h8, 32'd0);
        cycle("r023.b", g, og);
        chk("r023.second", 32'(og), 32'b10);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r023.idle2", g, og);

        // burst limit forces a switch after four grants
        pulse_reset();
        exp24 = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'b1, 1'b0, 32'(i) << 2, 32'd0);
            drive(1, 1'b1, 1'b0, 32'(15 - i) << 2, 32'd0);
            cycle("r024", g, og);
            chk($sformatf("r024.og%0d", i), 32'(og), 32'(exp24[i]));
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r024.idle", g, og);

        // port 1 write, then read it back through port 0
        drive(1, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
        #1;
        chk("r025.mem_we", 32'(mem_we), 32'd1);
        chk("r025.mem_addr", mem_addr, 32'h20);
        chk("r025.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        cycle("r025", g, og);
        chk("r025.rvalid1", 32'(rvalid1), 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r025.idle", g, og);
        chk("r025.we_off", 32'(mem_we), 32'd0);
        drive(0, 1'b1, 1'b0, 32'h20, 32'd0);
        cycle("r025.rd", g, og);
        chk("r025.rdback", rdata0, 32'hDEAD_BEEF);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r025.idle2", g, og);

        // reset in the middle of a port-0 burst
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 1'b0, 32'(i + 1) << 2, 32'd0);
            cycle("r026.burst", g, og);
        end
        drive(0, 1'b1, 1'b1, 32'h30, 32'h1111_2222);
        #1;
        chk("r026.pre_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("r026.gnt0", 32'(gnt0), 32'd0);
        chk("r026.mem_we", 32'(mem_we), 32'd0);
        chk("r026.rvalid0", 32'(rvalid0), 32'd0);
        model_reset();
        drive(0, 1'b1, 1'b0, 32'h4, 32'd0);
        cycle("r026.inrst", g, og);
        reset = 1'b0;
        drive(1, 1'b1, 1'b0, 32'h8, 32'd0);
        cycle("r026.post", g, og);
        chk("r026.first", 32'(og), 32'b01);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r026.idle", g, og);

        // long solo burst saturates; contender then wins at once
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, 1'(i & 1), 32'(i) << 2, 32'($urandom));
            cycle("r027", g, og);
            chk($sformatf("r027.og%0d", i), 32'(og), 32'b01);
        end
        drive(1, 1'b1, 1'b0, 32'h3C, 32'd0);
        cycle("r027.sw", g, og);
        chk("r027.switch", 32'(og), 32'b10);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle("r027.idle", g, og);

        // random traffic with held fields and occasional withdrawal
        pr = '{0, 0};
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pr[p]) begin
                    if ($urandom_range(9) < 6) begin
                        pr[p] = 1;
                        pw[p] = 1'($urandom_range(1));
                        pa[p] = 32'($urandom_range(15)) << 2;
                        pd[p] = $urandom;
                    end
                end else if ($urandom_range(15) == 0) begin
                    pr[p] = 0;
                end
                drive(p, pr[p], pw[p], pa[p], pd[p]);
            end
            cycle("rand", g, og);
            if (g >= 0) pr[g] = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
